// File: rtl/hold_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : hold_adc_capture
//  Function : On each HOLD rise, waits for the held level to settle, reads one
//             SPI frame from a serial ADC and presents the tagged sample on a
//             valid/ready interface. HOLD rises during a capture are flagged.
//  Revision : 1.0  initial release
// ============================================================================
module hold_adc_capture #(
    parameter int SETTLE_CYCLES = 50,
    parameter int SCLK_DIV      = 4,
    parameter int FRAME_BITS    = 16,
    parameter int ADC_BITS      = 12,
    parameter int QUIET_CYCLES  = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                capture_en_i,
    input  logic                hold_i,
    input  logic                adc_sdata_i,
    output logic                adc_cs_n_o,
    output logic                adc_sclk_o,
    output logic [ADC_BITS-1:0] sample_data_o,
    output logic [15:0]         event_num_o,
    output logic                sample_valid_o,
    input  logic                sample_ready_i,
    output logic                missed_hold_o,
    output logic                busy_o,
    input  logic                evt_load_i,
    input  logic [15:0]         evt_load_val_i
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int PHASE_W  = $clog2(2 * SCLK_DIV);
    localparam int BIT_W    = $clog2(FRAME_BITS + 1);
    localparam int QUIET_W  = $clog2(QUIET_CYCLES + 1);

    localparam logic [SETTLE_W-1:0] c_settle_last = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0]  c_sclk_div    = PHASE_W'(SCLK_DIV);
    localparam logic [PHASE_W-1:0]  c_phase_rise  = PHASE_W'(SCLK_DIV - 1);
    localparam logic [PHASE_W-1:0]  c_phase_last  = PHASE_W'(2 * SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]    c_bit_last    = BIT_W'(FRAME_BITS - 1);
    localparam logic [QUIET_W-1:0]  c_quiet_last  = QUIET_W'(QUIET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CONVERT = 3'd2,
        S_OUTPUT  = 3'd3,
        S_QUIET   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  hold_q;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [QUIET_W-1:0]    quiet_q, quiet_d;
    logic [ADC_BITS-1:0]   shift_q, shift_d;
    logic [ADC_BITS-1:0]   data_q, data_d;
    logic [15:0]           evt_q, evt_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  missed_q, missed_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  w_hold_rise;

    assign w_hold_rise = hold_i & ~hold_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        quiet_d  = quiet_q;
        shift_d  = shift_q;
        data_d   = data_q;
        evt_d    = evt_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        missed_d = w_hold_rise && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (w_hold_rise && capture_en_i) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                    evt_d    = cnt_q;
                    cnt_d    = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (settle_q == c_settle_last) begin
                    state_d = S_CONVERT;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_CONVERT: begin
                // Sample on the clock edge where SCLK goes low -> high
                if (phase_q == c_phase_rise) begin
                    shift_d = {shift_q[ADC_BITS-2:0], adc_sdata_i};
                end
                if (phase_q == c_phase_last) begin
                    phase_d = '0;
                    if (bit_q == c_bit_last) begin
                        state_d = S_OUTPUT;
                        data_d  = shift_q;
                        quiet_d = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                // Quiet time starts at CS_n rise, so it keeps counting here
                if (quiet_q != c_quiet_last) begin
                    quiet_d = quiet_q + 1'b1;
                end
                if (valid_q && sample_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_QUIET;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_QUIET: begin
                if (quiet_q == c_quiet_last) begin
                    state_d = S_IDLE;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (evt_load_i) begin
            cnt_d = evt_load_val_i;
        end

        cs_n_d = (state_d != S_CONVERT);
        sclk_d = !((state_d == S_CONVERT) && (phase_d < c_sclk_div));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            hold_q   <= 1'b0;
            settle_q <= '0;
            phase_q  <= '0;
            bit_q    <= '0;
            quiet_q  <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            evt_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_i;
            settle_q <= settle_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            quiet_q  <= quiet_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            evt_q    <= evt_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            missed_q <= missed_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
        end
    end

    assign adc_cs_n_o     = cs_n_q;
    assign adc_sclk_o     = sclk_q;
    assign sample_data_o  = data_q;
    assign event_num_o    = evt_q;
    assign sample_valid_o = valid_q;
    assign missed_hold_o  = missed_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hold_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hold_adc_capture
//  Function : Directed/random bench for hold_adc_capture with an SPI ADC model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hold_adc_capture;

    localparam int SETTLE = 50;
    localparam int FRAME  = 16 * 2 * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        hold = 1'b0;
    logic        sdata = 1'b0;
    logic        ready = 1'b0;
    logic        evt_load = 1'b0;
    logic [15:0] evt_load_val = 16'h0;
    logic        cs_n, sclk, valid, missed, busy;
    logic [11:0] data;
    logic [15:0] evt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    hold_adc_capture dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .capture_en_i   (en),
        .hold_i         (hold),
        .adc_sdata_i    (sdata),
        .adc_cs_n_o     (cs_n),
        .adc_sclk_o     (sclk),
        .sample_data_o  (data),
        .event_num_o    (evt),
        .sample_valid_o (valid),
        .sample_ready_i (ready),
        .missed_hold_o  (missed),
        .busy_o         (busy),
        .evt_load_i     (evt_load),
        .evt_load_val_i (evt_load_val)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: frame MSB first, next bit presented after each SCLK rise
    logic [15:0] adc_frame = 16'h0;
    logic [15:0] adc_active = 16'h0;
    logic        adc_prev_sclk = 1'b1;
    int          adc_idx = 0;
    always @(posedge clk) begin
        #1;
        if (cs_n) begin
            adc_idx    = 0;
            adc_active = adc_frame;
        end else if (sclk && !adc_prev_sclk) begin
            adc_idx = adc_idx + 1;
        end
        adc_prev_sclk = sclk;
        sdata = (adc_idx < 16) ? adc_active[15 - adc_idx] : 1'b0;
    end

    // Interface monitor, sampled mid-cycle
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
    int          cs_falls = 0, cs_fall_cyc = 0, cs_low_cnt = 0, sclk_rises = 0;
    int          valid_rise_cyc = 0, unstable = 0, missed_cnt = 0;
    logic [11:0] hold_data = '0;
    logic [15:0] hold_evt = '0;
    logic [27:0] acc_q[$];
    always @(negedge clk) begin
        if (prev_cs && !cs_n) begin
            cs_falls++;
            cs_fall_cyc = cyc;
            cs_low_cnt  = 0;
            sclk_rises  = 0;
        end
        if (!cs_n) begin
            cs_low_cnt++;
            if (!prev_sclk && sclk) sclk_rises++;
        end
        if (valid && !prev_valid) begin
            valid_rise_cyc = cyc;
            hold_data      = data;
            hold_evt       = evt;
        end
        if (valid && (data !== hold_data || evt !== hold_evt)) unstable++;
        if (valid && ready) acc_q.push_back({evt, data});
        if (missed) missed_cnt++;
        prev_cs    = cs_n;
        prev_sclk  = sclk;
        prev_valid = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic rise(output int rc);
        hold = 1'b1;
        rc   = cyc;
        step();
        hold = 1'b0;
    endtask

    task automatic pop_acc(output logic [27:0] v);
        if (acc_q.size() > 0) v = acc_q.pop_front();
        else v = '1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(valid), 32'd1);
    endtask

    initial begin
        int          r, r2, r3, f0, m0;
        logic [27:0] a;
        logic [15:0] fr, fr2;
        logic [15:0] exp_evt;

        // Reset state
        cycles(3);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_data", 32'(data), 32'd0);
        check("rst_evt", 32'(evt), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_missed", 32'(missed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_evt = 16'h0;

        // 1: basic capture, timing and frame shape
        cycles(10);
        adc_frame = 16'h0ABC;
        en = 1'b1;
        ready = 1'b1;
        rise(r);
        cycles(195);
        check("t1_cs_fall", 32'(cs_fall_cyc - r), 32'(1 + SETTLE));
        check("t1_cs_len", 32'(cs_low_cnt), 32'(FRAME));
        check("t1_sclk_pulses", 32'(sclk_rises), 32'd16);
        check("t1_valid_at", 32'(valid_rise_cyc - r), 32'(1 + SETTLE + FRAME + 1));
        check("t1_count", 32'(acc_q.size()), 32'd1);
        pop_acc(a);
        check("t1_data", 32'(a[11:0]), 32'h0ABC);
        check("t1_evt", 32'(a[27:12]), 32'(exp_evt));
        check("t1_idle", 32'(busy), 32'd0);
        exp_evt++;

        // 2: back-pressure, data/event stable until handshake
        fr = 16'($urandom);
        adc_frame = fr;
        ready = 1'b0;
        rise(r);
        wait_valid("t2_valid_rise", 250);
        cycles(20);
        check("t2_valid_held", 32'(valid), 32'd1);
        check("t2_data_held", 32'(data), 32'(fr[11:0]));
        check("t2_evt_held", 32'(evt), 32'(exp_evt));
        check("t2_stable", 32'(unstable), 32'd0);
        ready = 1'b1;
        step();
        check("t2_valid_drop", 32'(valid), 32'd0);
        pop_acc(a);
        check("t2_acc", 32'(a), {4'h0, exp_evt, fr[11:0]});
        exp_evt++;
        cycles(12);

        // 3: HOLD during capture is missed; only one sample
        fr = 16'($urandom);
        adc_frame = fr;
        m0 = missed_cnt;
        rise(r);
        cycles(29);
        rise(r2);
        cycles(200);
        check("t3_missed", 32'(missed_cnt - m0), 32'd1);
        check("t3_count", 32'(acc_q.size()), 32'd1);
        pop_acc(a);
        check("t3_acc", 32'(a), {4'h0, exp_evt, fr[11:0]});
        exp_evt++;

        // 3b: rise on the last QUIET cycle is missed, one cycle later accepted
        fr = 16'($urandom);
        adc_frame = fr;
        m0 = missed_cnt;
        rise(r);
        cycles(r + SETTLE + FRAME + 8 - cyc);
        check("t3b_quiet_busy", 32'(busy), 32'd1);
        fr2 = 16'($urandom);
        hold = 1'b1;
        step();
        hold = 1'b0;
        check("t3b_idle_min_spacing", 32'(busy), 32'd0);
        adc_frame = fr2;
        step();
        rise(r3);
        cycles(200);
        check("t3b_missed", 32'(missed_cnt - m0), 32'd1);
        check("t3b_cs_fall", 32'(cs_fall_cyc - r3), 32'(1 + SETTLE));
        check("t3b_count", 32'(acc_q.size()), 32'd2);
        pop_acc(a);
        check("t3b_acc0", 32'(a), {4'h0, exp_evt, fr[11:0]});
        exp_evt++;
        pop_acc(a);
        check("t3b_acc1", 32'(a), {4'h0, exp_evt, fr2[11:0]});
        exp_evt++;

        // 4: event counter wrap
        evt_load = 1'b1;
        evt_load_val = 16'hFFFF;
        step();
        evt_load = 1'b0;
        exp_evt = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            fr = 16'($urandom);
            adc_frame = fr;
            rise(r);
            cycles(200);
            pop_acc(a);
            check("t4_acc", 32'(a), {4'h0, exp_evt, fr[11:0]});
            exp_evt++;
        end
        check("t4_wrapped", 32'(evt), 32'h0000);

        // 5: disabled capture ignored; disabling mid-capture still completes
        en = 1'b0;
        f0 = cs_falls;
        m0 = missed_cnt;
        rise(r);
        cycles(200);
        check("t5_no_cs", 32'(cs_falls - f0), 32'd0);
        check("t5_no_missed", 32'(missed_cnt - m0), 32'd0);
        check("t5_no_sample", 32'(acc_q.size()), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        en = 1'b1;
        fr = 16'($urandom);
        adc_frame = fr;
        rise(r);
        cycles(r + 80 - cyc);
        check("t5_in_convert", 32'(cs_n), 32'd0);
        en = 1'b0;
        cycles(150);
        check("t5_count", 32'(acc_q.size()), 32'd1);
        pop_acc(a);
        check("t5_acc", 32'(a), {4'h0, exp_evt, fr[11:0]});
        exp_evt++;
        en = 1'b1;

        // 6: asynchronous reset during bit 7 of the frame
        fr = 16'($urandom);
        adc_frame = fr;
        rise(r);
        cycles(r + 1 + SETTLE + 7 * 8 + 2 - cyc);
        check("t6_in_convert", 32'(cs_n), 32'd0);
        check("t6_sclk_low", 32'(sclk), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_async_cs_n", 32'(cs_n), 32'd1);
        check("t6_async_sclk", 32'(sclk), 32'd1);
        check("t6_async_valid", 32'(valid), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        cycles(3);
        rst = 1'b0;
        exp_evt = 16'h0;
        cycles(5);
        check("t6_no_partial", 32'(acc_q.size()), 32'd0);
        fr = 16'($urandom);
        adc_frame = fr;
        rise(r);
        cycles(200);
        check("t6_count", 32'(acc_q.size()), 32'd1);
        pop_acc(a);
        check("t6_acc", 32'(a), {4'h0, exp_evt, fr[11:0]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
